// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between a memory stage and the data RAM responder
//   master: drives req_valid/req_we/req_addr/req_wdata and resp_ready
//   slave : drives req_ready, resp_valid, resp_rdata, resp_err
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data RAM responder with configurable wait states
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of data_mem_responder_if (request in, response out)
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] mem [2**ADDR_W];
  logic        accept, access, acc_we, in_range, ram_we;
  logic [15:0] acc_addr, acc_wdata;
  assign bus.req_ready  = rst && state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  always_comb begin
    accept    = bus.req_valid && bus.req_ready;
    // with no wait states the access uses the live request on its acceptance edge
    acc_we    = state_q == IDLE ? bus.req_we    : we_q;
    acc_addr  = state_q == IDLE ? bus.req_addr  : addr_q;
    acc_wdata = state_q == IDLE ? bus.req_wdata : wdata_q;
    in_range  = (acc_addr >> ADDR_W) == 16'd0;
    access    = ZERO_WAIT ? accept : (state_q == BUSY && cnt_q == 4'd0);
    ram_we    = access && acc_we && in_range;
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ZERO_WAIT ? RESP : BUSY;
        cnt_d   = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);
        we_d    = bus.req_we;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
      end
      BUSY: begin
        state_d = cnt_q == 4'd0 ? RESP : BUSY;
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      RESP:    state_d = bus.resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    if (access) begin
      rdata_d = (!acc_we && in_range) ? mem[acc_addr[ADDR_W-1:0]] : 16'h0000;
      err_d   = !in_range;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // RAM keeps its contents across reset; a reset forces IDLE, so a pending store never fires
  always_ff @(posedge clk) begin
    if (ram_we) mem[acc_addr[ADDR_W-1:0]] <= acc_wdata;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder (wait states 1, 3 and 0)
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  data_mem_responder_if if1 ();
  data_mem_responder_if if3 ();
  data_mem_responder_if if0 ();
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) d1 (.clk(clk), .rst(rst), .bus(if1.slave));
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) d3 (.clk(clk), .rst(rst), .bus(if3.slave));
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) d0 (.clk(clk), .rst(rst), .bus(if0.slave));
  always #5 if (clk_en) clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic txn1(input string tag, input logic we, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [15:0] exp_rdata, input logic exp_err);
    if1.req_valid = 1'b1;
    if1.req_we    = we;
    if1.req_addr  = addr;
    if1.req_wdata = wdata;
    step;
    if1.req_valid = 1'b0;
    if1.req_we    = ~we;
    if1.req_addr  = ~addr;
    if1.req_wdata = ~wdata;
    chk({tag, "_wait"}, 16'(if1.resp_valid), 16'd0);
    step;
    chk({tag, "_valid"}, 16'(if1.resp_valid), 16'd1);
    chk({tag, "_err"}, 16'(if1.resp_err), 16'(exp_err));
    chk({tag, "_rdata"}, if1.resp_rdata, exp_rdata);
    if1.resp_ready = 1'b1;
    step;
    if1.resp_ready = 1'b0;
    chk({tag, "_idle"}, 16'(if1.resp_valid), 16'd0);
    chk({tag, "_ready"}, 16'(if1.req_ready), 16'd1);
  endtask
  initial begin
    {if1.req_valid, if1.req_we, if1.req_addr, if1.req_wdata, if1.resp_ready} = '0;
    {if3.req_valid, if3.req_we, if3.req_addr, if3.req_wdata, if3.resp_ready} = '0;
    {if0.req_valid, if0.req_we, if0.req_addr, if0.req_wdata, if0.resp_ready} = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_valid1", 16'(if1.resp_valid), 16'd0);
    chk("rst_ready1", 16'(if1.req_ready), 16'd0);
    chk("rst_ready3", 16'(if3.req_ready), 16'd0);
    chk("rst_ready0", 16'(if0.req_ready), 16'd0);
    chk("rst_rdata1", if1.resp_rdata, 16'h0000);
    #2 rst = 1'b1;
    #1;
    chk("rel_ready1", 16'(if1.req_ready), 16'd1);
    clk_en = 1'b1;
    step;
    txn1("st10", 1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0);
    txn1("ld10", 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0);
    txn1("st00", 1'b1, 16'h0000, 16'h0BAD, 16'h0000, 1'b0);
    txn1("oor",  1'b1, 16'h0100, 16'hBEEF, 16'h0000, 1'b1);
    txn1("ld00", 1'b0, 16'h0000, 16'h0000, 16'h0BAD, 1'b0);
    if1.req_valid = 1'b1;
    if1.req_we    = 1'b0;
    if1.req_addr  = 16'h0010;
    step;
    step;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 16'(if1.resp_valid), 16'd1);
      chk("bp_rdata", if1.resp_rdata, 16'h1234);
      chk("bp_ready", 16'(if1.req_ready), 16'd0);
      step;
    end
    if1.resp_ready = 1'b1;
    step;
    chk("bp_rel_valid", 16'(if1.resp_valid), 16'd0);
    chk("bp_rel_ready", 16'(if1.req_ready), 16'd1);
    if1.req_valid  = 1'b0;
    if1.resp_ready = 1'b0;
    step;
    chk("bp_noaccept", 16'(if1.resp_valid), 16'd0);
    if3.req_valid = 1'b1;
    if3.req_we    = 1'b1;
    if3.req_addr  = 16'h0020;
    if3.req_wdata = 16'h00AA;
    step;
    if3.req_valid = 1'b0;
    step;
    step;
    chk("w3_lat", 16'(if3.resp_valid), 16'd0);
    step;
    chk("w3_valid", 16'(if3.resp_valid), 16'd1);
    if3.resp_ready = 1'b1;
    step;
    if3.resp_ready = 1'b0;
    chk("w3_idle", 16'(if3.resp_valid), 16'd0);
    if3.req_valid = 1'b1;
    if3.req_wdata = 16'h5555;
    step;
    if3.req_valid = 1'b0;
    step;
    rst = 1'b0;
    #1;
    chk("rb_valid", 16'(if3.resp_valid), 16'd0);
    chk("rb_ready", 16'(if3.req_ready), 16'd0);
    step;
    step;
    rst = 1'b1;
    #1;
    chk("rb_first_ready", 16'(if3.req_ready), 16'd1);
    step;
    step;
    step;
    step;
    chk("rb_no_resp", 16'(if3.resp_valid), 16'd0);
    if3.req_valid = 1'b1;
    if3.req_we    = 1'b0;
    step;
    if3.req_valid = 1'b0;
    step;
    step;
    step;
    chk("rb_ld_valid", 16'(if3.resp_valid), 16'd1);
    chk("rb_ld_rdata", if3.resp_rdata, 16'h00AA);
    if3.resp_ready = 1'b1;
    step;
    if3.resp_ready = 1'b0;
    txn1("ret", 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0);
    if0.resp_ready = 1'b1;
    if0.req_valid  = 1'b1;
    if0.req_we     = 1'b1;
    if0.req_addr   = 16'h0030;
    if0.req_wdata  = 16'h7777;
    step;
    chk("z_st_valid", 16'(if0.resp_valid), 16'd1);
    chk("z_st_err", 16'(if0.resp_err), 16'd0);
    chk("z_st_ready", 16'(if0.req_ready), 16'd0);
    if0.req_we = 1'b0;
    step;
    chk("z_gap_valid", 16'(if0.resp_valid), 16'd0);
    chk("z_gap_ready", 16'(if0.req_ready), 16'd1);
    step;
    chk("z_ld_valid", 16'(if0.resp_valid), 16'd1);
    chk("z_ld_rdata", if0.resp_rdata, 16'h7777);
    if0.req_addr = 16'h8000;
    step;
    chk("z_gap2_valid", 16'(if0.resp_valid), 16'd0);
    step;
    chk("z_oor_err", 16'(if0.resp_err), 16'd1);
    chk("z_oor_rdata", if0.resp_rdata, 16'h0000);
    if0.req_valid = 1'b0;
    step;
    chk("z_end_valid", 16'(if0.resp_valid), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
